ysyx_23060124_ifu: RTL and testbench

Instruction fetch unit of the ysyx_23060124 multi-cycle RV32 core. It holds the PC, issues one AXI4-Lite read per instruction, and presents the fetched word to the decode stage over the valid/ready handshake that the decoder consumes. It then waits for the write-back stage to return the next PC before it fetches again. One instruction is in flight at a time; there is no prefetch.

---
 rtl/ysyx_23060124_ifu.sv | 101 ++++++++++
 tb/tb_ysyx_23060124_ifu.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060124_ifu.sv
// ysyx_23060124_ifu: multi-cycle RV32 fetch unit, one AXI4-Lite read per instruction.
// Optional npc alignment check is enabled by defining YSYX_23060124_IFU_ALIGN_CHK_EN.
module ysyx_23060124_ifu #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_pre_valid,
    input  logic [ADDR_W-1:0] i_npc,
    output logic              o_pre_ready,
    output logic [31:0]       o_ins,
    output logic [ADDR_W-1:0] o_pc,
    output logic              o_post_valid,
    input  logic              i_post_ready,
    output logic [ADDR_W-1:0] o_araddr,
    output logic              o_arvalid,
    input  logic              i_arready,
    input  logic [31:0]       i_rdata,
    input  logic [1:0]        i_rresp,
    input  logic              i_rvalid,
    output logic              o_rready,
    output logic              o_ifu_err
);
    typedef enum logic [2:0] {S_AR, S_R, S_HOLD, S_WAIT, S_HALT} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       ins_q, ins_d;
    logic              err_q, err_d;

    // Next state and data: each state only looks at its own handshake input.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ins_d   = ins_q;
        err_d   = err_q;
        case (state_q)
            S_AR:   state_d = i_arready ? S_R : S_AR;
            S_R: begin
                if (i_rvalid && i_rresp == 2'b00) begin
                    ins_d   = i_rdata;
                    state_d = S_HOLD;
                end else if (i_rvalid) begin
                    err_d   = 1'b1;
                    state_d = S_HALT;
                end
            end
            S_HOLD: state_d = i_post_ready ? S_WAIT : S_HOLD;
            S_WAIT: begin
                if (i_pre_valid) begin
`ifdef YSYX_23060124_IFU_ALIGN_CHK_EN
                    if (|i_npc[1:0]) begin
                        err_d   = 1'b1;
                        state_d = S_HALT;
                    end else begin
                        pc_d    = i_npc;
                        state_d = S_AR;
                    end
`else
                    pc_d    = i_npc;
                    state_d = S_AR;
`endif
                end
            end
            default: state_d = S_HALT;
        endcase
    end

    // State register; reset restarts fetch at RESET_PC and clears the sticky error.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_AR;
            pc_q    <= RESET_PC;
            ins_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ins_q   <= ins_d;
            err_q   <= err_d;
        end
    end

`ifdef YSYX_23060124_IFU_ALIGN_CHK_EN
    // Report a misaligned redirect at the moment it is rejected.
    always_ff @(posedge i_clk) begin
        if (!i_rst && state_q == S_WAIT && i_pre_valid && |i_npc[1:0])
            $display("ysyx_23060124_ifu: misaligned npc %h", i_npc);
    end
`endif

    assign o_arvalid    = !i_rst && state_q == S_AR;
    assign o_rready     = !i_rst && state_q == S_R;
    assign o_post_valid = !i_rst && state_q == S_HOLD;
    assign o_pre_ready  = !i_rst && state_q == S_WAIT;
    assign o_araddr     = pc_q;
    assign o_pc         = pc_q;
    assign o_ins        = ins_q;
    assign o_ifu_err    = err_q;
endmodule

// File: tb/tb_ysyx_23060124_ifu.sv
// tb_ysyx_23060124_ifu: directed scoreboard bench for the fetch unit.
module tb_ysyx_23060124_ifu;
    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic        i_clk = 1'b0;
    logic        i_rst, i_pre_valid, i_post_ready, i_arready, i_rvalid;
    logic [31:0] i_npc, i_rdata;
    logic [1:0]  i_rresp;
    logic        o_pre_ready, o_post_valid, o_arvalid, o_rready, o_ifu_err;
    logic [31:0] o_ins, o_pc, o_araddr;

    typedef struct {logic [31:0] pc; logic [31:0] ins;} exp_t;
    exp_t        sb[$];
    exp_t        e;
    int          checks = 0;
    int          errors = 0;
    int          ar_hs = 0;
    int          hs0;
    logic [31:0] last_ins;

    ysyx_23060124_ifu dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_pre_valid(i_pre_valid), .i_npc(i_npc), .o_pre_ready(o_pre_ready),
        .o_ins(o_ins), .o_pc(o_pc), .o_post_valid(o_post_valid), .i_post_ready(i_post_ready),
        .o_araddr(o_araddr), .o_arvalid(o_arvalid), .i_arready(i_arready),
        .i_rdata(i_rdata), .i_rresp(i_rresp), .i_rvalid(i_rvalid), .o_rready(o_rready),
        .o_ifu_err(o_ifu_err)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) if (o_arvalid && i_arready) ar_hs++;

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, want);
        end
    endtask

    // Entered in AR; leaves the DUT in WAIT after the decode handshake.
    task automatic fetch(input logic [31:0] addr, input logic [31:0] data, input int ar_stall, input int hold_stall);
        hs0 = ar_hs;
        chk("ar_valid", {31'b0, o_arvalid}, 32'd1);
        chk("ar_addr", o_araddr, addr);
        for (int i = 0; i < ar_stall; i++) begin
            i_arready = 1'b0;
            i_rvalid  = 1'b1;
            step();
            chk("ar_stall_valid", {31'b0, o_arvalid}, 32'd1);
            chk("ar_stall_addr", o_araddr, addr);
        end
        i_rvalid  = 1'b0;
        i_arready = 1'b1;
        step();
        i_arready = 1'b0;
        chk("ar_one_hs", ar_hs - hs0, 32'd1);
        chk("r_ready", {31'b0, o_rready}, 32'd1);
        chk("r_arvalid_low", {31'b0, o_arvalid}, 32'd0);
        i_rvalid = 1'b1;
        i_rdata  = data;
        i_rresp  = 2'b00;
        sb.push_back('{pc: addr, ins: data});
        step();
        i_rvalid = 1'b0;
        i_rdata  = 32'hffff_ffff;
        chk("hold_postv", {31'b0, o_post_valid}, 32'd1);
        for (int i = 0; i < hold_stall; i++) begin
            i_post_ready = 1'b0;
            i_pre_valid  = 1'b1;
            i_npc        = 32'h0000_bad0;
            step();
            chk("stall_postv", {31'b0, o_post_valid}, 32'd1);
            chk("stall_ins", o_ins, data);
            chk("stall_pc", o_pc, addr);
            chk("stall_pre_ready", {31'b0, o_pre_ready}, 32'd0);
        end
        i_pre_valid = 1'b0;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL sb_empty observed=0 expected=1");
        end else begin
            e = sb.pop_front();
            chk("sb_ins", o_ins, e.ins);
            chk("sb_pc", o_pc, e.pc);
        end
        last_ins = data;
        i_post_ready = 1'b1;
        step();
        i_post_ready = 1'b0;
        chk("wait_pre_ready", {31'b0, o_pre_ready}, 32'd1);
        chk("wait_postv", {31'b0, o_post_valid}, 32'd0);
    endtask

    // Entered in WAIT; presents npc in the first WAIT cycle.
    task automatic redirect(input logic [31:0] npc);
        i_pre_valid = 1'b1;
        i_npc       = npc;
        step();
        i_pre_valid = 1'b0;
    endtask

    initial begin
        i_rst = 1'b1; i_pre_valid = 1'b0; i_post_ready = 1'b0; i_arready = 1'b0;
        i_rvalid = 1'b0; i_npc = '0; i_rdata = '0; i_rresp = 2'b00;
        repeat (3) step();
        chk("rst_arvalid", {31'b0, o_arvalid}, 32'd0);
        chk("rst_rready", {31'b0, o_rready}, 32'd0);
        chk("rst_postv", {31'b0, o_post_valid}, 32'd0);
        chk("rst_pre_ready", {31'b0, o_pre_ready}, 32'd0);
        chk("rst_pc", o_pc, RST_PC);
        chk("rst_ins", o_ins, 32'd0);
        chk("rst_err", {31'b0, o_ifu_err}, 32'd0);
        i_rst = 1'b0;
        step();
        fetch(RST_PC, 32'h0000_0413, 0, 0);
        redirect(32'h8000_0004);
        fetch(32'h8000_0004, 32'h0010_0093, 4, 0);
        redirect(32'h8000_0008);
        fetch(32'h8000_0008, 32'h0020_8133, 0, 5);
        redirect(32'h8000_0010);
        fetch(32'h8000_0010, 32'h0000_0513, 0, 0);
        // AR and R offered together: only the address phase may complete.
        redirect(32'h8000_0014);
        chk("sim_araddr", o_araddr, 32'h8000_0014);
        i_arready = 1'b1; i_rvalid = 1'b1; i_rdata = 32'h1111_1111;
        step();
        i_arready = 1'b0;
        chk("sim_in_r", {31'b0, o_rready}, 32'd1);
        chk("sim_postv", {31'b0, o_post_valid}, 32'd0);
        chk("sim_ins_kept", o_ins, 32'h0000_0513);
        i_rdata = 32'h0040_0593;
        sb.push_back('{pc: 32'h8000_0014, ins: 32'h0040_0593});
        step();
        i_rvalid = 1'b0;
        e = sb.pop_front();
        chk("sim_ins", o_ins, e.ins);
        chk("sim_pc", o_pc, e.pc);
        i_post_ready = 1'b1;
        step();
        i_post_ready = 1'b0;
        // Bus error halts until reset.
        redirect(32'h8000_0020);
        i_arready = 1'b1;
        step();
        i_arready = 1'b0;
        i_rvalid = 1'b1; i_rresp = 2'b10; i_rdata = 32'hdead_beef;
        step();
        i_rvalid = 1'b0; i_rresp = 2'b00;
        chk("err_set", {31'b0, o_ifu_err}, 32'd1);
        chk("err_postv", {31'b0, o_post_valid}, 32'd0);
        chk("err_ins_kept", o_ins, 32'h0040_0593);
        i_arready = 1'b1; i_rvalid = 1'b1; i_post_ready = 1'b1; i_pre_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("halt_err", {31'b0, o_ifu_err}, 32'd1);
            chk("halt_hs", {28'b0, o_arvalid, o_rready, o_post_valid, o_pre_ready}, 32'd0);
        end
        i_arready = 1'b0; i_rvalid = 1'b0; i_post_ready = 1'b0; i_pre_valid = 1'b0;
        i_rst = 1'b1;
        step();
        chk("err_clr", {31'b0, o_ifu_err}, 32'd0);
        i_rst = 1'b0;
        step();
        chk("restart_pc", o_pc, RST_PC);
        // Misaligned redirect.
        fetch(RST_PC, 32'h0000_0413, 0, 0);
        redirect(32'h8000_0002);
`ifdef YSYX_23060124_IFU_ALIGN_CHK_EN
        chk("mis_err", {31'b0, o_ifu_err}, 32'd1);
        chk("mis_no_ar", {31'b0, o_arvalid}, 32'd0);
        chk("mis_pc_kept", o_pc, RST_PC);
`else
        chk("mis_ar", {31'b0, o_arvalid}, 32'd1);
        chk("mis_addr", o_araddr, 32'h8000_0002);
        chk("mis_no_err", {31'b0, o_ifu_err}, 32'd0);
`endif
        chk("sb_drained", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
